// File: rtl/imem_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_ctrl_pkg
// Brief    : Shared types and constants for the instruction-memory boot
//            controller (state encoding, NOP instruction, default width).
// Revision : 1.0 - initial release
// ============================================================================
package imem_boot_ctrl_pkg;

  // Default word-address width of the instruction memory (2^15 words)
  localparam int DEFAULT_ADDR_W = 15;

  // Instruction handed to fetch whenever the core is not running (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage : imem_boot_ctrl_pkg
`default_nettype wire

// File: rtl/imem_boot_ctrl_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_ctrl_byte_word_assembler
// Brief    : Collects four little-endian bytes into a 32-bit word. The word
//            and its done pulse are presented combinationally with the 4th
//            byte so the caller can register the result on that same edge.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl_byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // The 4th byte completes the word this cycle; it is never stored here
  assign word_done = byte_valid && (lane == 2'd3);
  assign word      = {byte_data, low_bytes};

  // Lane counter and storage for the three lower bytes of the word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= 24'd0;
      endcase
    end
  end

endmodule : imem_boot_ctrl_byte_word_assembler
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_ctrl
// Brief    : Owns the instruction-memory port. Loads a length-prefixed image
//            from the UART byte stream while holding the core, then hands
//            the read port to fetch and releases core_hold.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int          ADDR_W = DEFAULT_ADDR_W,
  parameter logic [31:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_ir,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_err
);

  // Largest accepted word count: the whole memory
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   n_words;
  logic              accept;
  logic              reload_ok;
  logic              word_done;
  logic [31:0]       word;

  // Only the word-address bits of the PC reach the memory
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0]};

  // Once the final word has been written, DATA lingers one cycle (the write
  // commit cycle) with the RX side closed so no trailing byte is swallowed.
  assign rx_ready  = (state == ST_LEN) ||
                     ((state == ST_DATA) && (word_cnt != n_words));
  assign accept    = rx_valid && rx_ready;
  assign reload_ok = reload && ((state == ST_RUN) || (state == ST_ERR));

  assign mem_raddr = fetch_pc[ADDR_W+1:2];
  assign fetch_ir  = (state == ST_RUN) ? mem_rdata : NOP;

  imem_boot_ctrl_byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_ok),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word_done  (word_done),
    .word       (word)
  );

  // Load sequencer with registered memory-write and core-control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LEN;
      word_cnt  <= '0;
      n_words   <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
      core_hold <= 1'b1;
      load_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_LEN: begin
          if (word_done) begin
            if (word == 32'd0) begin
              state <= ST_FLUSH;
            end else if ({1'b0, word} > MAX_WORDS) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              n_words  <= word[ADDR_W:0];
              word_cnt <= '0;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Counter reaching N means word N-1 is committing this cycle
          if (word_cnt == n_words) begin
            state <= ST_FLUSH;
          end else if (word_done) begin
            mem_we    <= 1'b1;
            mem_waddr <= word_cnt[ADDR_W-1:0];
            mem_wdata <= word;
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          state     <= ST_RUN;
          core_hold <= 1'b0;
        end
        ST_RUN, ST_ERR: begin
          if (reload) begin
            state     <= ST_LEN;
            word_cnt  <= '0;
            n_words   <= '0;
            core_hold <= 1'b1;
            load_err  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_LEN;
          core_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule : imem_boot_ctrl
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_ctrl
// Brief    : Directed self-checking bench for imem_boot_ctrl with a simple
//            behavioural instruction RAM and a log of every write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_ctrl;

  localparam int          AW  = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          reload = 1'b0;
  logic [31:0]   fetch_pc = 32'd0;
  logic [31:0]   fetch_ir;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          load_err;

  int tests = 0;
  int fails = 0;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic [AW-1:0] log_addr [$];
  logic [31:0]   log_data [$];

  always #5 clk = ~clk;

  imem_boot_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .fetch_pc  (fetch_pc),
    .fetch_ir  (fetch_ir),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_err  (load_err)
  );

  assign mem_rdata = ram[mem_raddr];

  // Behavioural RAM plus a record of each write cycle
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_waddr] <= mem_wdata;
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (rx_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (rx_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL rx_ready_timeout: got %b required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL reset_core_hold: got %b required 1", core_hold); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err: got %b required 0", load_err); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    tests++; if (mem_waddr !== 15'd0) begin fails++; $display("FAIL reset_mem_waddr: got %0h required 0", mem_waddr); end
    tests++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_wdata: got %0h required 0", mem_wdata); end
    tests++; if (fetch_ir !== NOP) begin fails++; $display("FAIL reset_fetch_ir: got %08h required %08h", fetch_ir, NOP); end
    tests++; if (mem_raddr !== 15'h10) begin fails++; $display("FAIL reset_mem_raddr: got %0h required 10", mem_raddr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
  endtask

  task automatic test_load_basic();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h0000_0013; exp_d[1] = 32'h0010_0093; exp_d[2] = 32'hDEAD_BEEF;
    clear_log();
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(exp_d[i], 0);
    tests++; if (mem_we !== 1'b1 || mem_waddr !== 15'd2 || mem_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL basic_last_write: got we=%b addr=%0h data=%08h required we=1 addr=2 data=deadbeef", mem_we, mem_waddr, mem_wdata); end
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL basic_hold_t0: got %b required 1", core_hold); end
    @(posedge clk); #1;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL basic_we_one_cycle: got %b required 0", mem_we); end
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL basic_hold_flush: got %b required 1", core_hold); end
    @(posedge clk); #1;
    tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL basic_hold_run: got %b required 0", core_hold); end
    tests++; if (log_addr.size() != 3) begin fails++; $display("FAIL basic_write_count: got %0d required 3", log_addr.size()); end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      tests++; if (log_addr[i] !== 15'(i) || log_data[i] !== exp_d[i]) begin
        fails++; $display("FAIL basic_write_%0d: got addr=%0h data=%08h required addr=%0h data=%08h", i, log_addr[i], log_data[i], i, exp_d[i]); end
    end
    fetch_pc = 32'd8; #1;
    tests++; if (fetch_ir !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_fetch_pc8: got %08h required deadbeef", fetch_ir); end
    fetch_pc = 32'd4; #1;
    tests++; if (fetch_ir !== 32'h0010_0093) begin fails++; $display("FAIL basic_fetch_pc4: got %08h required 00100093", fetch_ir); end
  endtask

  task automatic test_zero_len();
    fetch_pc = 32'd8;
    pulse_reload();
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL zero_reload_hold: got %b required 1", core_hold); end
    tests++; if (fetch_ir !== NOP) begin fails++; $display("FAIL zero_reload_nop: got %08h required %08h", fetch_ir, NOP); end
    clear_log();
    send_word(32'd0, 0);
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL zero_hold_flush: got %b required 1", core_hold); end
    @(posedge clk); #1;
    tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL zero_hold_run: got %b required 0", core_hold); end
    fetch_pc = 32'd4; #1;
    tests++; if (fetch_ir !== 32'h0010_0093) begin fails++; $display("FAIL zero_fetch: got %08h required 00100093", fetch_ir); end
    tests++; if (log_addr.size() != 0) begin fails++; $display("FAIL zero_no_write: got %0d writes required 0", log_addr.size()); end
  endtask

  task automatic test_len_err();
    pulse_reload();
    send_word(32'h0000_8001, 0);
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL err_load_err: got %b required 1", load_err); end
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL err_rx_ready: got %b required 0", rx_ready); end
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL err_core_hold: got %b required 1", core_hold); end
    tests++; if (fetch_ir !== NOP) begin fails++; $display("FAIL err_fetch_nop: got %08h required %08h", fetch_ir, NOP); end
    repeat (3) @(posedge clk); #1;
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL err_held: got %b required 1", load_err); end
    pulse_reload();
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL err_reload_clear: got %b required 0", load_err); end
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL err_reload_ready: got %b required 1", rx_ready); end
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL err_reload_hold: got %b required 1", core_hold); end
  endtask

  task automatic test_gapped();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hA1B2_C3D4; exp_d[1] = 32'h1122_3344;
    clear_log();
    send_word(32'd2, 4);
    send_word(exp_d[0], 4);
    send_word(exp_d[1], 4);
    repeat (2) @(posedge clk); #1;
    tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL gap_run: got %b required 0", core_hold); end
    tests++; if (log_addr.size() != 2) begin fails++; $display("FAIL gap_write_count: got %0d required 2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      tests++; if (log_addr[i] !== 15'(i) || log_data[i] !== exp_d[i]) begin
        fails++; $display("FAIL gap_write_%0d: got addr=%0h data=%08h required addr=%0h data=%08h", i, log_addr[i], log_data[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_rst_mid_load();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hCAFE_F00D; exp_d[1] = 32'h1234_5678;
    pulse_reload();
    clear_log();
    send_word(32'd3, 0);
    send_word(32'h5566_7788, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL rst_mid_hold: got %b required 1", core_hold); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid_we: got %b required 0", mem_we); end
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_len: got rx_ready=%b required 1", rx_ready); end
    tests++; if (mem_waddr !== 15'd0) begin fails++; $display("FAIL rst_mid_waddr: got %0h required 0", mem_waddr); end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_word(32'd2, 0);
    send_word(exp_d[0], 0);
    send_word(exp_d[1], 0);
    repeat (2) @(posedge clk); #1;
    tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL rst_reload_run: got %b required 0", core_hold); end
    tests++; if (log_addr.size() != 2) begin fails++; $display("FAIL rst_reload_count: got %0d required 2", log_addr.size()); end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      tests++; if (log_addr[i] !== 15'(i) || log_data[i] !== exp_d[i]) begin
        fails++; $display("FAIL rst_reload_write_%0d: got addr=%0h data=%08h required addr=%0h data=%08h", i, log_addr[i], log_data[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_reload_in_data();
    fetch_pc = 32'd0;
    #1;
    tests++; if (fetch_ir !== 32'hCAFE_F00D) begin fails++; $display("FAIL run_fetch: got %08h required cafef00d", fetch_ir); end
    pulse_reload();
    tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL run_reload_hold: got %b required 1", core_hold); end
    tests++; if (fetch_ir !== NOP) begin fails++; $display("FAIL run_reload_nop: got %08h required %08h", fetch_ir, NOP); end
    clear_log();
    send_word(32'd1, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hC0, 0);
    pulse_reload();
    tests++; if (rx_ready !== 1'b1 || core_hold !== 1'b1) begin
      fails++; $display("FAIL data_reload_ignored: got rx_ready=%b hold=%b required 1 1", rx_ready, core_hold); end
    send_byte(8'hAD, 0);
    send_byte(8'h0B, 0);
    repeat (2) @(posedge clk); #1;
    tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL data_reload_run: got %b required 0", core_hold); end
    tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL data_reload_count: got %0d required 1", log_addr.size()); end
    if (log_addr.size() > 0) begin
      tests++; if (log_addr[0] !== 15'd0 || log_data[0] !== 32'h0BAD_C0DE) begin
        fails++; $display("FAIL data_reload_write: got addr=%0h data=%08h required addr=0 data=0badc0de", log_addr[0], log_data[0]); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hFFFF_FFFF;
    test_reset();
    test_load_basic();
    test_zero_len();
    test_len_err();
    test_gapped();
    test_rst_mid_load();
    test_reload_in_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
`default_nettype wire

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Owns the instruction-memory port and sequences it between two users: a byte-stream bootloader (UART receiver side) that writes a program image, and the fetch stage that reads instructions by PC. After reset it holds the core, loads a length-prefixed image word by word, then hands the read port to fetch. It sits between the UART RX, the instruction RAM and the fetch stage, and gates the core's run enable.

## Interface
- ADDR_W, 15: word-address width; memory depth is 2^ADDR_W words.
- NOP, 32'h00000013: instruction returned to fetch while not running.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available from UART RX.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte accepted on a cycle with rx_valid&rx_ready.
- reload  in  1  one-cycle request to re-enter loading from RUN or ERR.
- fetch_pc  in  32  byte PC from fetch.
- fetch_ir  out  32  instruction to fetch.
- mem_raddr  out  ADDR_W  read word address = fetch_pc[ADDR_W+1:2].
- mem_rdata  in  32  combinational read data of mem_raddr.
- mem_we  out  1  write strobe, one cycle per word.
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- core_hold  out  1  high: core must not advance PC.
- load_err  out  1  image length invalid.

## Operation
- States: LEN (collect 4-byte word count N, little-endian), DATA (collect N words, each 4 bytes little-endian), FLUSH (one cycle, lets last write commit), RUN, ERR.
- Reset: state=LEN, byte counter=0, word counter=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_hold=1, load_err=0.
- rx_ready=1 in LEN and DATA, 0 otherwise; bytes arriving in RUN/ERR are not consumed.
- 2-bit byte counter selects the byte lane (byte 0 -> bits 7:0); wraps after 4 bytes.
- LEN complete: N==0 -> FLUSH; N>2^ADDR_W -> ERR (load_err=1); else DATA with word counter=0.
- DATA: on 4th byte of a word, register mem_we=1, mem_waddr=word counter, mem_wdata=assembled word; increment word counter (ADDR_W+1 bits). If that word is index N-1, next state FLUSH.
- FLUSH -> RUN unconditionally; core_hold falls on entry to RUN.
- RUN: fetch_ir=mem_rdata; elsewhere fetch_ir=NOP. mem_raddr always follows fetch_pc.
- reload in RUN or ERR: state=LEN, counters cleared, core_hold=1, load_err=0. reload in LEN/DATA/FLUSH is ignored.
- ERR: core_hold=1, load_err=1, held until reload or rst.
- rst mid-load: immediate return to LEN; partially written memory is not cleared.

## Timing
- rx handshake completes in the accepting cycle; one byte per cycle sustained.
- 4th byte of word k accepted at edge T: mem_we high for cycle T..T+1 exactly, address k.
- Last word accepted at edge T: FLUSH during T+1..T+2, RUN and core_hold=0 from edge T+2.
- N==0: LEN completes at edge T, RUN from edge T+1, no mem_we.
- fetch_ir combinational from mem_rdata and registered state; zero added latency in RUN.
- core_hold, load_err, mem_* are registered outputs.

## Structure
- Shared package: state enum (LEN, DATA, FLUSH, RUN, ERR), NOP constant, default ADDR_W.
- One sub-module natural: byte_word_assembler (2-bit lane counter, 32-bit shift/lane register, word_done pulse), reused for LEN and DATA.
- Memory array itself stays outside this block.

## Test plan
- Reset, stream N=3 then 0x00000013, 0x00100093, 0xDEADBEEF -> writes at 0,1,2 with those values; core_hold=0 two cycles after last byte; fetch_pc=8 gives fetch_ir=0xDEADBEEF.
- N=0 -> no mem_we, RUN one cycle after 4th length byte, fetch_ir=mem_rdata.
- N=2^ADDR_W+1 -> ERR, load_err=1, rx_ready=0, fetch_ir=NOP; reload -> LEN, load_err=0.
- Gapped rx_valid (1 byte every 5 cycles) -> identical write sequence to back-to-back stream.
- rst asserted after 6 bytes of data -> immediate LEN, core_hold=1, mem_we=0; reload of full image then succeeds.
- reload pulse during DATA -> ignored, load completes; reload in RUN -> core_hold=1 next edge, fetch_ir=NOP.
